// File: rtl/store_pkg.sv
// Shared types and helpers for the store queue: funct3 encodings, the queued entry
// format and the size/alignment rules for S-type stores.
package store_pkg;

  localparam int SQ_N = 13;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef struct packed {
    logic [SQ_N-1:0] addr;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
  } sq_entry_t;

  // Strobe for the access size before it is shifted into its byte lane.
  function automatic logic [7:0] size_strobe(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   return 8'h01;
      F3_SH:   return 8'h03;
      F3_SW:   return 8'h0F;
      F3_SD:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3)
      F3_SB:   return 1'b1;
      F3_SH:   return off[0] == 1'b0;
      F3_SW:   return off[1:0] == 2'b00;
      F3_SD:   return off == 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_queue_lane_align.sv
// Enqueue-side formatter: turns a raw store into a doubleword-aligned address,
// lane-shifted data and byte strobe, and flags misaligned or illegal stores.
module store_lane_align
  import store_pkg::*;
#(
  parameter int N = SQ_N
) (
  input  logic [N-1:0] st_addr,
  input  logic [63:0]  st_data,
  input  logic [2:0]   st_funct3,
  output logic [N-1:0] al_addr,
  output logic [63:0]  al_data,
  output logic [7:0]   al_strb,
  output logic         al_err
);

  logic [2:0]  off;
  logic [7:0]  base_strb;
  logic [63:0] byte_mask;

  always_comb begin
    off       = st_addr[2:0];
    base_strb = size_strobe(st_funct3);
    byte_mask = '0;
    // Drop source bits above the access size before shifting into the lane.
    for (int b = 0; b < 8; b++) begin
      byte_mask[8*b +: 8] = {8{base_strb[b]}};
    end
    al_addr = {st_addr[N-1:3], 3'b000};
    al_data = (st_data & byte_mask) << {off, 3'b000};
    al_strb = base_strb << off;
    al_err  = !is_aligned(st_funct3, off);
  end

endmodule

// File: rtl/store_queue.sv
// In-order store buffer between store execute and a single-port data memory:
// accepts one store per cycle, drains via req/gnt, and flags load-address hazards.
module store_queue
  import store_pkg::*;
#(
  parameter int N     = SQ_N,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [N-1:0] st_addr,
  input  logic [63:0]  st_data,
  input  logic [2:0]   st_funct3,
  output logic         misalign_err,
  output logic         mem_req,
  input  logic         mem_gnt,
  output logic [N-1:0] mem_addr,
  output logic [63:0]  mem_wdata,
  output logic [7:0]   mem_wstrb,
  input  logic [N-1:0] ld_addr,
  output logic         ld_hazard,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [N-1:0] DW_MASK = {{(N-3){1'b1}}, 3'b000};

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          state_q;
  sq_entry_t       ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]   wptr_q, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            misalign_q, mem_req_q, empty_q;
  logic [N-1:0]    mem_addr_q;
  logic [63:0]     mem_wdata_q;
  logic [7:0]      mem_wstrb_q;

  logic [N-1:0]    al_addr;
  logic [63:0]     al_data;
  logic [7:0]      al_strb;
  logic            al_err;
  logic            full, hs, push, pop;
  sq_entry_t       push_ent, head_d;

  store_lane_align #(.N(N)) u_align (
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .al_addr   (al_addr),
    .al_data   (al_data),
    .al_strb   (al_strb),
    .al_err    (al_err)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign st_ready = !full && !rst;
  assign hs       = st_valid && st_ready;
  assign push     = hs && !al_err;
  assign pop      = (state_q == S_REQ) && mem_gnt;

  always_comb begin
    push_ent = '{addr: al_addr, wdata: al_data, wstrb: al_strb};
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // When the queue drains to nothing this cycle, the next head is the incoming store.
    head_d   = (count_q == CW'(pop)) ? push_ent : ent_q[rptr_d];
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (((ent_q[i].addr ^ ld_addr) & DW_MASK) == '0)) ld_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_q[wptr_q] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vld_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      misalign_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      empty_q     <= 1'b1;
    end else begin
      misalign_q <= hs && al_err;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      rptr_q     <= rptr_d;
      if (pop) vld_q[rptr_q] <= 1'b0;
      if (push) begin
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (count_d != '0) begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= head_d.addr;
            mem_wdata_q <= head_d.wdata;
            mem_wstrb_q <= head_d.wstrb;
          end
        end
        S_REQ: begin
          if (pop) begin
            if (count_d != '0) begin
              mem_addr_q  <= head_d.addr;
              mem_wdata_q <= head_d.wdata;
              mem_wstrb_q <= head_d.wstrb;
            end else begin
              state_q   <= S_IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign misalign_err = misalign_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign empty        = empty_q;

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_store_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [12:0] st_addr;
  logic [63:0] st_data;
  logic [2:0]  st_funct3;
  logic        misalign_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [12:0] ld_addr;
  logic        ld_hazard;
  logic        empty;

  int vecs = 0;
  int errs = 0;
  logic [12:0] wr_log[$];

  store_queue #(.N(13), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3), .misalign_err(misalign_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt) wr_log.push_back(mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [12:0] a, input logic [63:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; st_valid = 1'b0; mem_gnt = 1'b0; ld_addr = '0;
    st_addr = '0; st_data = '0; st_funct3 = '0;
    tick(); tick();
    vecs++; if (st_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %0b want 0", st_ready); end
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %0b want 0", mem_req); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty: got %0b want 1", empty); end
    vecs++; if (misalign_err !== 1'b0) begin errs++; $display("FAIL rst_misalign: got %0b want 0", misalign_err); end
    vecs++; if ({mem_addr, mem_wdata, mem_wstrb} !== '0) begin errs++;
      $display("FAIL rst_memout: got addr=%h data=%h strb=%h want 0", mem_addr, mem_wdata, mem_wstrb); end
    vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL rst_hazard: got %0b want 0", ld_hazard); end
    rst = 1'b0; #1;
    vecs++; if (st_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_rel: got %0b want 1", st_ready); end
  endtask

  task automatic test_sb();
    mem_gnt = 1'b1;
    drive_store(3'b000, 13'h005, 64'h0000_0000_0000_00AB);
    tick();
    st_valid = 1'b0;
    vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL sb_req: got %0b want 1", mem_req); end
    vecs++; if (mem_addr !== 13'h000) begin errs++; $display("FAIL sb_addr: got %h want 000", mem_addr); end
    vecs++; if (mem_wdata !== 64'h0000_AB00_0000_0000) begin errs++; $display("FAIL sb_data: got %h want 0000ab0000000000", mem_wdata); end
    vecs++; if (mem_wstrb !== 8'h20) begin errs++; $display("FAIL sb_strb: got %h want 20", mem_wstrb); end
    vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL sb_notempty: got %0b want 0", empty); end
    tick();
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL sb_empty: got %0b want 1", empty); end
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL sb_req_drop: got %0b want 0", mem_req); end
    mem_gnt = 1'b0;
  endtask

  task automatic test_sh();
    mem_gnt = 1'b1;
    drive_store(3'b001, 13'h006, 64'hDEAD_BEEF_CAFE_1234);
    tick();
    st_valid = 1'b0;
    vecs++; if (mem_wdata !== 64'h1234_0000_0000_0000) begin errs++; $display("FAIL sh_data: got %h want 1234000000000000", mem_wdata); end
    vecs++; if (mem_wstrb !== 8'hC0) begin errs++; $display("FAIL sh_strb: got %h want c0", mem_wstrb); end
    vecs++; if (mem_addr !== 13'h000) begin errs++; $display("FAIL sh_addr: got %h want 000", mem_addr); end
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic test_misalign();
    int base;
    base = wr_log.size();
    mem_gnt = 1'b1;
    drive_store(3'b010, 13'h006, 64'h1);
    tick();
    st_valid = 1'b0;
    vecs++; if (misalign_err !== 1'b1) begin errs++; $display("FAIL sw_mis_err: got %0b want 1", misalign_err); end
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL sw_mis_req: got %0b want 0", mem_req); end
    tick();
    vecs++; if (misalign_err !== 1'b0) begin errs++; $display("FAIL sw_mis_pulse: got %0b want 0", misalign_err); end
    drive_store(3'b100, 13'h000, 64'h2);
    tick();
    st_valid = 1'b0;
    vecs++; if (misalign_err !== 1'b1) begin errs++; $display("FAIL f3_ill_err: got %0b want 1", misalign_err); end
    tick();
    vecs++; if (misalign_err !== 1'b0) begin errs++; $display("FAIL f3_ill_pulse: got %0b want 0", misalign_err); end
    vecs++; if (empty !== 1'b1 || mem_req !== 1'b0) begin errs++;
      $display("FAIL mis_queue: got empty=%0b req=%0b want 1/0", empty, mem_req); end
    vecs++; if (wr_log.size() !== base) begin errs++; $display("FAIL mis_writes: got %0d want %0d", wr_log.size(), base); end
    mem_gnt = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_gnt = 1'b1;
    drive_store(3'b000, 13'h100, 64'h01);
    tick();
    vecs++; if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 13'h100, 64'h01, 8'h01}) begin errs++;
      $display("FAIL b2b_0: got req=%0b addr=%h data=%h strb=%h want 1/100/01/01", mem_req, mem_addr, mem_wdata, mem_wstrb); end
    drive_store(3'b001, 13'h10A, 64'hBEEF);
    tick();
    vecs++; if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 13'h108, 64'h0000_0000_BEEF_0000, 8'h0C}) begin errs++;
      $display("FAIL b2b_1: got req=%0b addr=%h data=%h strb=%h want 1/108/beef0000/0c", mem_req, mem_addr, mem_wdata, mem_wstrb); end
    drive_store(3'b010, 13'h114, 64'hCAFE_F00D);
    tick();
    st_valid = 1'b0;
    vecs++; if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 13'h110, 64'hCAFE_F00D_0000_0000, 8'hF0}) begin errs++;
      $display("FAIL b2b_2: got req=%0b addr=%h data=%h strb=%h want 1/110/cafef00d00000000/f0", mem_req, mem_addr, mem_wdata, mem_wstrb); end
    tick();
    vecs++; if (mem_req !== 1'b0 || empty !== 1'b1) begin errs++;
      $display("FAIL b2b_drain: got req=%0b empty=%0b want 0/1", mem_req, empty); end
    mem_gnt = 1'b0;
  endtask

  task automatic test_full();
    int base;
    logic [12:0] exp_a;
    base = wr_log.size();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(3'b011, 13'(8 * (i + 1)), 64'(i + 1));
      tick();
    end
    drive_store(3'b011, 13'h028, 64'h5);
    #1;
    vecs++; if (st_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %0b want 0", st_ready); end
    tick(); tick();
    vecs++; if (st_ready !== 1'b0 || mem_addr !== 13'h008 || mem_wstrb !== 8'hFF) begin errs++;
      $display("FAIL full_stall: got ready=%0b addr=%h strb=%h want 0/008/ff", st_ready, mem_addr, mem_wstrb); end
    mem_gnt = 1'b1;
    tick();
    vecs++; if (st_ready !== 1'b1 || mem_addr !== 13'h010) begin errs++;
      $display("FAIL full_pop1: got ready=%0b addr=%h want 1/010", st_ready, mem_addr); end
    tick();
    st_valid = 1'b0;
    for (int t = 0; t < 20 && empty !== 1'b1; t++) tick();
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL full_drain_timeout: got empty=%0b want 1", empty); end
    vecs++; if (wr_log.size() !== base + 5) begin errs++;
      $display("FAIL full_count: got %0d writes want 5", wr_log.size() - base); end
    for (int i = 0; i < 5 && base + i < wr_log.size(); i++) begin
      exp_a = 13'(8 * (i + 1));
      vecs++; if (wr_log[base + i] !== exp_a) begin errs++;
        $display("FAIL full_order%0d: got %h want %h", i, wr_log[base + i], exp_a); end
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_hazard();
    mem_gnt = 1'b0;
    drive_store(3'b010, 13'h108, 64'h55);
    ld_addr = 13'h10C;
    #1;
    vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL haz_incoming: got %0b want 0", ld_hazard); end
    tick();
    st_valid = 1'b0;
    #1;
    vecs++; if (ld_hazard !== 1'b1) begin errs++; $display("FAIL haz_10c: got %0b want 1", ld_hazard); end
    ld_addr = 13'h110; #1;
    vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL haz_110: got %0b want 0", ld_hazard); end
    ld_addr = 13'h10C;
    mem_gnt = 1'b1;
    tick();
    vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL haz_after_gnt: got %0b want 0", ld_hazard); end
    mem_gnt = 1'b0;
    ld_addr = '0;
  endtask

  task automatic test_reset_mid();
    int base;
    mem_gnt = 1'b0;
    drive_store(3'b000, 13'h040, 64'h1); tick();
    drive_store(3'b000, 13'h048, 64'h2); tick();
    drive_store(3'b000, 13'h050, 64'h3); tick();
    st_valid = 1'b0;
    vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rmid_req_pre: got %0b want 1", mem_req); end
    base = wr_log.size();
    rst = 1'b1; mem_gnt = 1'b1;
    tick();
    rst = 1'b0; #1;
    vecs++; if (mem_req !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin errs++;
      $display("FAIL rmid_state: got req=%0b empty=%0b ready=%0b want 0/1/1", mem_req, empty, st_ready); end
    tick(); tick(); tick();
    vecs++; if (wr_log.size() !== base || mem_req !== 1'b0) begin errs++;
      $display("FAIL rmid_stale: got %0d writes req=%0b want 0/0", wr_log.size() - base, mem_req); end
    ld_addr = 13'h048; #1;
    vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL rmid_hazard: got %0b want 0", ld_hazard); end
    mem_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_misalign();
    test_back_to_back();
    test_full();
    test_hazard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
Store queue sitting between the S-type store execute stage and the single-port data memory.
- Accepts one store per cycle over a valid/ready handshake.
- Converts each store to a doubleword-aligned write with byte strobes.
- Buffers up to DEPTH stores in order and drains them to memory with a request/grant handshake.
- Flags stores that are not naturally aligned.
- Reports load-address hazards against pending stores so the load path can stall.

Parameters:
N, 13, byte-address width of data memory
DEPTH, 4, queue entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
st_valid  in  1  store request valid
st_ready  out  1  queue can accept a store this cycle
st_addr  in  N  byte address (reg1+imm, truncated)
st_data  in  64  source data, right-justified (reg2)
st_funct3  in  3  000 SB, 001 SH, 010 SW, 011 SD
misalign_err  out  1  one-cycle pulse: accepted store was misaligned or had an illegal funct3 and was dropped
mem_req  out  1  write request to data memory
mem_gnt  in  1  memory accepts the current request this cycle
mem_addr  out  N  doubleword-aligned address, low 3 bits zero
mem_wdata  out  64  lane-shifted write data
mem_wstrb  out  8  byte-enable, bit i enables byte i
ld_addr  in  N  address of the load in execute
ld_hazard  out  1  combinational: a pending store overlaps ld_addr's doubleword
empty  out  1  queue holds no entries (fence/drain indicator)

Behaviour:
- Reset (rst=1 at an edge):
  - Pointers and count go to 0; FSM goes to IDLE; all entries are invalidated.
  - misalign_err=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, empty=1.
  - st_ready=0 while rst is high.
  - Reset mid-operation discards all queued stores, including one currently being requested.
- Accept: a handshake occurs when st_valid && st_ready. st_ready = !full && !rst. A pop does not free a slot in the same cycle (no full-bypass).
- Alignment:
  - SH requires addr[0]=0; SW requires addr[1:0]=0; SD requires addr[2:0]=0.
  - A misaligned store, or funct3 outside 000-011, is consumed and not enqueued. misalign_err is registered and high for exactly the cycle after the handshake.
- Lane formatting at enqueue, with off=addr[2:0]:
  - SB: data=st_data[7:0]<<(8*off), strb=0x01<<off.
  - SH: data=st_data[15:0]<<(8*off), strb=0x03<<off.
  - SW: data=st_data[31:0]<<(8*off), strb=0x0F<<off.
  - SD: data=st_data, strb=0xFF.
  - Stored address is {addr[N-1:3],3'b000}.
- FSM IDLE/REQ:
  - IDLE: mem_req=0; go to REQ when count>0.
  - REQ: mem_req=1, with mem_addr/mem_wdata/mem_wstrb from the head entry, registered and held stable until grant.
  - On mem_gnt in REQ: pop the head. Stay in REQ if count after the pop is >0 (the next head is presented in the next cycle); otherwise go to IDLE.
  - mem_gnt is ignored in IDLE.
- Latency: a store accepted at edge k gives mem_req=1 in cycle k+1 if the queue was empty. Throughput is 1 store/cycle under continuous grant.
- Simultaneous push and pop: both take effect; count is unchanged; order is preserved (FIFO).
- Pointers wrap modulo DEPTH. full = (count==DEPTH).
- When REQ is not active, mem_addr/mem_wdata/mem_wstrb hold their last values (don't-care to memory).
- ld_hazard: OR over valid entries of (entry.addr[N-1:3]==ld_addr[N-1:3]). It includes the entry currently being requested and excludes a store being accepted in the same cycle.
- empty = (count==0), registered view.

Decomposition:
- Package store_pkg:
  - funct3 constants F3_SB/F3_SH/F3_SW/F3_SD.
  - Typedef sq_entry_t {addr, wdata, wstrb}.
  - Function size_strobe(funct3) returning the unshifted strobe.
  - Function is_aligned(funct3, off).
- One combinational sub-module, store_lane_align: inputs st_addr/st_data/st_funct3; outputs aligned address, shifted data, strobe, and err. It is instantiated once at the enqueue side.

Test Plan:
- SB addr=0x005 data=0xAB, mem_gnt=1 -> next cycle mem_req=1, mem_addr=0x000, mem_wdata=0x0000_AB00_0000_0000, mem_wstrb=0x20; empty=1 after the grant cycle.
- SH addr=0x006 data=0x1234 -> mem_wdata=0x1234_0000_0000_0000, mem_wstrb=0xC0, mem_addr=0x000.
- SW addr=0x006, and funct3=3'b100 addr=0x000 -> misalign_err pulses once each, mem_req never rises, empty stays 1.
- mem_gnt=0; push SD to 0x008/0x010/0x018/0x020 -> st_ready=0 after the 4th; a held 5th store stalls. Raise mem_gnt -> writes issue in order 0x008..0x020, the 5th is accepted the cycle after the first pop, and the total is 5 writes with no loss.
- SW to 0x108 queued with mem_gnt=0 -> ld_addr=0x10C gives ld_hazard=1 and ld_addr=0x110 gives 0. After the grant, ld_hazard=0 for 0x10C.
- Three stores queued, mem_req=1, assert rst for 1 cycle with mem_gnt=1 -> no pop is counted. After reset: mem_req=0, empty=1, st_ready=1, and no stale write is issued.
